// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {RF_CLEAR, RF_RUN} rf_state_t;

  function automatic int unsigned rf_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Fill bit for the clear sweep, replicated to the data width by users.
  localparam logic RF_CLR_VAL = '0;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear/run sequencer: owns state, sweep index, wr_drop, and muxes the sweep
// write against the user write onto a single memory write port.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic              o_wr_drop,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data
);

  localparam int unsigned       DEPTH    = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic              r_wr_drop, w_wr_drop_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RF_CLEAR;
      r_idx     <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_wr_drop <= w_wr_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_wr_drop_nxt = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_addr    = i_waddr;
    o_mem_data    = i_wdata;
    unique case (r_state)
      RF_CLEAR: begin
        o_mem_we      = 1'b1;
        o_mem_addr    = r_idx;
        o_mem_data    = {DATA_W{RF_CLR_VAL}};
        w_wr_drop_nxt = i_we;
        // A clear request during the sweep restarts it from entry 0.
        if (i_clr) begin
          w_idx_nxt = '0;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = RF_RUN;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + ADDR_W'(1);
        end
      end
      RF_RUN: begin
        o_mem_we = i_we && !((ZERO_REG != 0) && (i_waddr == '0));
        if (i_clr) begin
          w_state_nxt = RF_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      default: w_state_nxt = RF_CLEAR;
    endcase
  end

  assign o_ready   = (r_state == RF_RUN);
  assign o_wr_drop = r_wr_drop;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one write port, NUM_RD combinational read ports.
// Define REGFILE_BYPASS_EN for write-first forwarding; default is read-first.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     ready,
  output logic                     wr_drop
);

  localparam int unsigned DEPTH = rf_depth(ADDR_W);

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic [ADDR_W-1:0] w_ra;
  logic [DATA_W-1:0] r_mem [DEPTH];

  regfile_clear_fsm #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_clear_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (clr),
    .i_we       (we),
    .i_waddr    (waddr),
    .i_wdata    (wdata),
    .o_ready    (ready),
    .o_wr_drop  (wr_drop),
    .o_mem_we   (w_mem_we),
    .o_mem_addr (w_mem_addr),
    .o_mem_data (w_mem_data)
  );

  // Contents are left unreset; the clear sweep initialises them.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_comb begin
    rdata = '0;
    w_ra  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_ra = raddr[k*ADDR_W +: ADDR_W];
      if (!ready || ((ZERO_REG != 0) && (w_ra == '0))) begin
        rdata[k*DATA_W +: DATA_W] = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (we && (waddr == w_ra)) begin
        rdata[k*DATA_W +: DATA_W] = wdata;
`endif
      end else begin
        rdata[k*DATA_W +: DATA_W] = r_mem[w_ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp against a sweep-count/array reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic          ready;
  logic          wr_drop;

  int errors = 0;
  int checks = 0;

  // Reference model: memory image, edges left until the file is usable, expected wr_drop.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_sweep;
  logic          m_drop;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (raddr),
    .rdata   (rdata),
    .ready   (ready),
    .wr_drop (wr_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_sweep = DEPTH;
    m_drop  = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endfunction

  function automatic void model_edge();
    if (m_sweep != 0) begin
      m_drop  = we;
      m_sweep = clr ? DEPTH : m_sweep - 1;
    end else begin
      m_drop = 1'b0;
      if (we && waddr != 0) m_mem[waddr] = wdata;
      if (clr) begin
        m_sweep = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (m_sweep != 0 || a == 0) return '0;
    if (BYPASS && we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic start_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    we    = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    model_reset();
    #2;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++;
    if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %b expected 0", wr_drop); end
    checks++;
    if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL reset_sweep_len: got %0d expected %0d", n, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(DEPTH - 1 - a));
      #1;
      checks++;
      if (rdata !== '0) begin
        errors++; $display("FAIL post_reset_read a=%0d: got %h expected 0", a, rdata);
      end
    end
  endtask

  task automatic test_write();
    set_rd(0, 5); set_rd(1, 5);
    we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (rdata[0 +: DW] !== (BYPASS ? 32'hDEADBEEF : 32'h0)) begin
      errors++; $display("FAIL write_same_cycle: got %h expected %h", rdata[0 +: DW],
                         BYPASS ? 32'hDEADBEEF : 32'h0);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata[0 +: DW] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_after_edge p0: got %h expected deadbeef", rdata[0 +: DW]);
    end
    checks++;
    if (rdata[DW +: DW] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_after_edge p1: got %h expected deadbeef", rdata[DW +: DW]);
    end
  endtask

  task automatic test_zero_reg();
    set_rd(0, 0);
    we = 1'b1; waddr = 0; wdata = 32'h12345678;
    #1;
    checks++;
    if (rdata[0 +: DW] !== '0) begin
      errors++; $display("FAIL zero_same_cycle: got %h expected 0", rdata[0 +: DW]);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata[0 +: DW] !== '0) begin
      errors++; $display("FAIL zero_after_edge: got %h expected 0", rdata[0 +: DW]);
    end
    checks++;
    if (wr_drop !== 1'b0) begin errors++; $display("FAIL zero_wr_drop: got %b expected 0", wr_drop); end
  endtask

  task automatic test_drop();
    int n;
    start_reset();
    tick();
    tick();
    we = 1'b1; waddr = 9; wdata = 32'hCAFEF00D;
    tick();
    we = 1'b0;
    checks++;
    if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b expected 1", wr_drop); end
    tick();
    checks++;
    if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse_end: got %b expected 0", wr_drop); end
    n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL drop_ready_timeout: got %b expected 1", ready); end
    set_rd(0, 9);
    #1;
    checks++;
    if (rdata[0 +: DW] !== '0) begin
      errors++; $display("FAIL drop_target: got %h expected 0", rdata[0 +: DW]);
    end
  endtask

  task automatic test_clr();
    int n;
    for (int a = 1; a < DEPTH; a++) begin
      we = 1'b1; waddr = AW'(a); wdata = DW'(a);
      tick();
    end
    we = 1'b0;
    set_rd(0, 17); set_rd(1, 31);
    #1;
    checks++;
    if (rdata !== {32'd31, 32'd17}) begin
      errors++; $display("FAIL clr_prefill: got %h expected %h", rdata, {32'd31, 32'd17});
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      set_rd(0, AW'($urandom_range(0, DEPTH - 1)));
      set_rd(1, AW'($urandom_range(0, DEPTH - 1)));
      #1;
      checks++;
      if (rdata !== '0) begin
        errors++; $display("FAIL clr_sweep_read n=%0d: got %h expected 0", n, rdata);
      end
      tick();
      n++;
    end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL clr_sweep_len: got %0d expected %0d", n, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, AW'(a)); set_rd(1, AW'(a));
      #1;
      checks++;
      if (rdata !== '0) begin
        errors++; $display("FAIL clr_after a=%0d: got %h expected 0", a, rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    start_reset();
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b expected 0", ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL mid_reset_sweep_len: got %0d expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 400; i++) begin
      we    = 1'($urandom_range(0, 1));
      waddr = AW'($urandom_range(0, DEPTH - 1));
      wdata = $urandom;
      clr   = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NR; p++) begin
        a = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
        set_rd(p, a);
      end
      #1;
      checks++;
      if (ready !== (m_sweep == 0)) begin
        errors++; $display("FAIL rand_ready i=%0d: got %b expected %b", i, ready, m_sweep == 0);
      end
      checks++;
      if (wr_drop !== m_drop) begin
        errors++; $display("FAIL rand_wr_drop i=%0d: got %b expected %b", i, wr_drop, m_drop);
      end
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (rdata[p*DW +: DW] !== exp_rd(raddr[p*AW +: AW])) begin
          errors++;
          $display("FAIL rand_read i=%0d p=%0d: got %h expected %h", i, p, rdata[p*DW +: DW],
                   exp_rd(raddr[p*AW +: AW]));
        end
      end
      tick();
    end
    we  = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_zero_reg();
    test_drop();
    test_clr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
